// File: rtl/c7bexu_pkg.sv
// Shared types and constants for the c7b execution-unit writeback/interlock controller.
package c7bexu_pkg;

  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned DIV_LAT_DEFAULT = 8;
  localparam int unsigned DIV_CNT_W       = 4;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_IN_E = 2'd1,
    DIV_RUN  = 2'd2
  } div_state_e;

  // True when decode actually reads register x (r0 never matches).
  function automatic logic srcmatch(input logic [REG_ADDR_W-1:0] x,
                                    input logic [REG_ADDR_W-1:0] rs1,
                                    input logic                  rs1_use,
                                    input logic [REG_ADDR_W-1:0] rs2,
                                    input logic                  rs2_use);
    return (x != '0) && ((rs1_use && (rs1 == x)) || (rs2_use && (rs2 == x)));
  endfunction

endpackage

// File: rtl/c7bexu_divsb.sv
// Divider scoreboard: tracks one outstanding divide, times its writeback strobe
// and flags decode hazards against its destination.
module c7bexu_divsb
  import c7bexu_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_i,
  input  logic                  valid_i,
  input  logic                  is_div_i,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  wen_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic                  rs1_use_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  rs2_use_i,
  output logic                  busy_o,
  output logic                  wb_en_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o,
  output logic                  stall_o
);

  div_state_e            state_q, state_d;
  logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  busy_q, busy_d;
  logic                  wb_en_q, wb_en_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      wb_rd_q <= '0;
      busy_q  <= 1'b0;
      wb_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_rd_q <= wb_rd_d;
      busy_q  <= busy_d;
      wb_en_q <= wb_en_d;
    end
  end

  // Strobe and busy are registered from the next-state so they line up with state_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_rd_d = wb_rd_q;
    case (state_q)
      DIV_IDLE: begin
        if (issue_i && is_div_i) begin
          state_d = DIV_IN_E;
          cnt_d   = DIV_CNT_W'(DIV_LAT - 1);
          wb_rd_d = rd_i;
        end
      end
      DIV_IN_E: begin
        if (flush_i) begin
          state_d = DIV_IDLE;
        end else begin
          state_d = DIV_RUN;
          cnt_d   = cnt_q - DIV_CNT_W'(1);
        end
      end
      DIV_RUN: begin
        if (cnt_q == '0) state_d = DIV_IDLE;
        else             cnt_d   = cnt_q - DIV_CNT_W'(1);
      end
      default: state_d = DIV_IDLE;
    endcase
    busy_d  = (state_d != DIV_IDLE);
    wb_en_d = (state_d == DIV_RUN) && (cnt_d == '0) && (wb_rd_d != '0);
  end

  // Structural, RAW and WAW hazards against the outstanding divide.
  assign stall_o = busy_q &&
                   ((valid_i && is_div_i) ||
                    srcmatch(wb_rd_q, rs1_i, rs1_use_i, rs2_i, rs2_use_i) ||
                    (wen_i && (rd_i == wb_rd_q) && (rd_i != '0)));

  assign busy_o  = busy_q;
  assign wb_en_o = wb_en_q;
  assign wb_rd_o = wb_rd_q;

endmodule

// File: rtl/c7bexu_wbctl.sv
// Destination-tag pipeline (E/M/W) and decode interlock for the c7b execution unit.
// Define C7B_EXU_DIV_EN to include the fixed-latency divider scoreboard.
module c7bexu_wbctl
  import c7bexu_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  wen_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  rs1_use_d,
  input  logic                  rs2_use_d,
  input  logic                  is_load_d,
  input  logic                  is_div_d,
  input  logic                  flush_e,
  output logic                  stall_d,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic [REG_ADDR_W-1:0] rd_m,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic                  wen_e,
  output logic                  wen_m,
  output logic                  wen_w,
  output logic                  div_busy,
  output logic                  div_wb_en,
  output logic [REG_ADDR_W-1:0] div_wb_rd
);

  logic [REG_ADDR_W-1:0] rd_e_q, rd_m_q, rd_w_q;
  logic                  wen_e_q, wen_m_q, wen_w_q, load_e_q;
  logic                  wen_e_d, load_e_d;
  logic                  load_stall_c, div_stall_c, stall_c, issue_c, div_op_c;

  assign load_stall_c = load_e_q && srcmatch(rd_e_q, rs1_d, rs1_use_d, rs2_d, rs2_use_d);
  assign stall_c      = !reset && (load_stall_c || div_stall_c);
  assign issue_c      = valid_d && !stall_c && !flush_e;

`ifdef C7B_EXU_DIV_EN
  assign div_op_c = is_div_d;

  c7bexu_divsb #(.DIV_LAT(DIV_LAT)) u_divsb (
    .clk       (clk),
    .reset     (reset),
    .issue_i   (issue_c),
    .valid_i   (valid_d),
    .is_div_i  (is_div_d),
    .flush_i   (flush_e),
    .rd_i      (rd_d),
    .wen_i     (wen_d),
    .rs1_i     (rs1_d),
    .rs1_use_i (rs1_use_d),
    .rs2_i     (rs2_d),
    .rs2_use_i (rs2_use_d),
    .busy_o    (div_busy),
    .wb_en_o   (div_wb_en),
    .wb_rd_o   (div_wb_rd),
    .stall_o   (div_stall_c)
  );
`else
  // Without the divider a divide is an ordinary ALU write through the E/M/W path.
  localparam int unsigned unused_div_lat = DIV_LAT;
  logic unused_div_c;
  assign unused_div_c = is_div_d;
  assign div_op_c     = 1'b0;
  assign div_stall_c  = 1'b0;
  assign div_busy     = 1'b0;
  assign div_wb_en    = 1'b0;
  assign div_wb_rd    = '0;
`endif

  always_comb begin
    wen_e_d  = issue_c && wen_d && !div_op_c && (rd_d != '0);
    load_e_d = issue_c && is_load_d && wen_d && (rd_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_e_q   <= '0;
      rd_m_q   <= '0;
      rd_w_q   <= '0;
      wen_e_q  <= 1'b0;
      wen_m_q  <= 1'b0;
      wen_w_q  <= 1'b0;
      load_e_q <= 1'b0;
    end else begin
      rd_e_q   <= rd_d;
      wen_e_q  <= wen_e_d;
      load_e_q <= load_e_d;
      rd_m_q   <= rd_e_q;
      wen_m_q  <= wen_e_q && !flush_e;
      rd_w_q   <= rd_m_q;
      wen_w_q  <= wen_m_q;
    end
  end

  assign stall_d = stall_c;
  assign rd_e    = rd_e_q;
  assign rd_m    = rd_m_q;
  assign rd_w    = rd_w_q;
  assign wen_e   = wen_e_q;
  assign wen_m   = wen_m_q;
  assign wen_w   = wen_w_q;

endmodule

// File: tb/tb_c7bexu_wbctl.sv
// Scoreboard bench for c7bexu_wbctl: a cycle-level reference model pushes expected
// outputs per cycle; a negedge monitor pops and compares.
module tb_c7bexu_wbctl;

  localparam int unsigned LAT = 8;

  logic       clk = 1'b0;
  logic       reset, valid_d, wen_d, rs1_use_d, rs2_use_d, is_load_d, is_div_d, flush_e;
  logic [4:0] rd_d, rs1_d, rs2_d;
  logic       stall_d, wen_e, wen_m, wen_w, div_busy, div_wb_en;
  logic [4:0] rd_e, rd_m, rd_w, div_wb_rd;

  c7bexu_wbctl #(.DIV_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .rd_d(rd_d), .wen_d(wen_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_use_d(rs1_use_d), .rs2_use_d(rs2_use_d),
    .is_load_d(is_load_d), .is_div_d(is_div_d), .flush_e(flush_e),
    .stall_d(stall_d), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .wen_e(wen_e), .wen_m(wen_m), .wen_w(wen_w),
    .div_busy(div_busy), .div_wb_en(div_wb_en), .div_wb_rd(div_wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       r, v;
    logic [4:0] rd;
    logic       wen;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2, ld, dv, fl;
  } stim_t;

  typedef struct {
    int         cyc;
    logic       stall, wen_e, wen_m, wen_w, busy, wb_en;
    logic [4:0] rd_e, rd_m, rd_w, wb_rd;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state: instruction tags sitting in each stage, plus the outstanding divide.
  logic       e_wen, e_load, m_wen, w_wen;
  logic [4:0] e_rd, m_rd, w_rd;
  bit         div_act;
  int         div_iss;
  logic [4:0] div_rd;
  int         cyc;

  function automatic bit reads(input logic [4:0] x, input stim_t s);
    return (x != 0) && ((s.u1 && s.rs1 == x) || (s.u2 && s.rs2 == x));
  endfunction

  function automatic stim_t ins(input int rd, input bit wen, input int rs1, input bit u1,
                                input int rs2, input bit u2, input bit ld, input bit dv);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.rd = 5'(rd); s.wen = wen; s.rs1 = 5'(rs1); s.u1 = u1;
    s.rs2 = 5'(rs2); s.u2 = u2; s.ld = ld; s.dv = dv;
    return s;
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h want %0h", nm, c, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("stall_d",   e.cyc, 32'(stall_d),   32'(e.stall));
      chk("wen_e",     e.cyc, 32'(wen_e),     32'(e.wen_e));
      chk("rd_e",      e.cyc, 32'(rd_e),      32'(e.rd_e));
      chk("wen_m",     e.cyc, 32'(wen_m),     32'(e.wen_m));
      chk("rd_m",      e.cyc, 32'(rd_m),      32'(e.rd_m));
      chk("wen_w",     e.cyc, 32'(wen_w),     32'(e.wen_w));
      chk("rd_w",      e.cyc, 32'(rd_w),      32'(e.rd_w));
      chk("div_busy",  e.cyc, 32'(div_busy),  32'(e.busy));
      chk("div_wb_en", e.cyc, 32'(div_wb_en), 32'(e.wb_en));
      chk("div_wb_rd", e.cyc, 32'(div_wb_rd), 32'(e.wb_rd));
    end
  end

  task automatic model_clear();
    e_wen = 0; e_load = 0; m_wen = 0; w_wen = 0;
    e_rd = 0; m_rd = 0; w_rd = 0;
    div_act = 0; div_iss = -100; div_rd = 0;
  endtask

  // Drive one cycle of decode inputs, record what the DUT must show this cycle, advance the model.
  task automatic step(input stim_t s, output bit issued);
    exp_t x;
    bit   busy, lu, dstall, stall;
    @(posedge clk); #1;
    reset = s.r; valid_d = s.v; rd_d = s.rd; wen_d = s.wen; rs1_d = s.rs1; rs1_use_d = s.u1;
    rs2_d = s.rs2; rs2_use_d = s.u2; is_load_d = s.ld; is_div_d = s.dv; flush_e = s.fl;

`ifdef C7B_EXU_DIV_EN
    busy   = div_act && (cyc > div_iss) && (cyc <= div_iss + int'(LAT));
    dstall = busy && ((s.v && s.dv) || reads(div_rd, s) ||
                      (s.wen && s.rd == div_rd && s.rd != 0));
`else
    busy   = 0;
    dstall = 0;
`endif
    lu    = e_load && reads(e_rd, s);
    stall = !s.r && (lu || dstall);

    x.cyc = cyc; x.stall = stall;
    x.wen_e = e_wen; x.rd_e = e_rd; x.wen_m = m_wen; x.rd_m = m_rd; x.wen_w = w_wen; x.rd_w = w_rd;
    x.busy = busy; x.wb_rd = div_rd;
    x.wb_en = busy && (cyc == div_iss + int'(LAT)) && (div_rd != 0);
    sbq.push_back(x);

    issued = 0;
    if (s.r) begin
      model_clear();
    end else begin
      issued = s.v && !stall && !s.fl;
      w_wen = m_wen;          w_rd = m_rd;
      m_wen = e_wen && !s.fl; m_rd = e_rd;
`ifdef C7B_EXU_DIV_EN
      e_wen = issued && s.wen && !s.dv && s.rd != 0;
      if (div_act && s.fl && cyc == div_iss + 1) div_act = 0;
      if (div_act && cyc == div_iss + int'(LAT)) div_act = 0;
      if (issued && s.dv) begin
        div_act = 1; div_iss = cyc; div_rd = s.rd;
      end
`else
      e_wen = issued && s.wen && s.rd != 0;
`endif
      e_rd   = s.rd;
      e_load = issued && s.ld && s.wen && s.rd != 0;
    end
    cyc++;
  endtask

  // Present one instruction until it issues; a bounded wait so an interlock that never releases fails.
  task automatic issue_hold(input stim_t s);
    bit iss;
    for (int k = 0; k < 40; k++) begin
      step(s, iss);
      if (iss) return;
    end
    n_vec++; n_bad++;
    $display("FAIL issue_hold cycle %0d: got no-issue want issue within 40 cycles", cyc);
  endtask

  task automatic idle(input int n);
    bit iss;
    for (int k = 0; k < n; k++) step('0, iss);
  endtask

  initial begin
    stim_t s, cur;
    bit    iss, have;
    reset = 1; valid_d = 0; rd_d = 0; wen_d = 0; rs1_d = 0; rs2_d = 0;
    rs1_use_d = 0; rs2_use_d = 0; is_load_d = 0; is_div_d = 0; flush_e = 0;
    repeat (3) @(posedge clk);
    model_clear();
    cyc = 0;

    // Reset state, then ALU write to r5 and a write to r0.
    idle(1);
    issue_hold(ins(5, 1, 0, 0, 0, 0, 0, 0));
    issue_hold(ins(0, 1, 1, 1, 0, 0, 0, 0));
    idle(4);

    // Load-use: exactly one bubble.
    issue_hold(ins(7, 1, 2, 1, 0, 0, 1, 0));
    issue_hold(ins(8, 1, 7, 1, 3, 1, 0, 0));
    idle(3);

    // Divide then dependent add; then back-to-back divides.
    issue_hold(ins(9, 1, 1, 1, 2, 1, 0, 1));
    issue_hold(ins(10, 1, 4, 1, 9, 1, 0, 0));
    issue_hold(ins(11, 1, 1, 1, 2, 1, 0, 1));
    issue_hold(ins(12, 1, 1, 1, 2, 1, 0, 1));
    idle(LAT + 2);

    // Divide flushed in E; ALU op flushed in E; flush together with a load-use stall.
    issue_hold(ins(13, 1, 0, 0, 0, 0, 0, 1));
    s = '0; s.fl = 1; step(s, iss);
    idle(LAT + 1);
    issue_hold(ins(14, 1, 0, 0, 0, 0, 0, 0));
    s = ins(15, 1, 0, 0, 0, 0, 0, 0); s.fl = 1; step(s, iss);
    issue_hold(ins(16, 1, 0, 0, 0, 0, 1, 0));
    s = ins(17, 1, 16, 1, 0, 0, 0, 0); s.fl = 1; step(s, iss);
    idle(3);

    // Reset while a divide is running.
    issue_hold(ins(18, 1, 0, 0, 0, 0, 0, 1));
    issue_hold(ins(19, 1, 0, 0, 0, 0, 0, 0));
    idle(LAT - 4);
    s = '0; s.r = 1; s.v = 1; s.wen = 1; s.rd = 5'd20; step(s, iss);
    idle(LAT + 2);

    // Randomized traffic over a small register set to provoke hazards; held while stalled.
    have = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!have) begin
        cur = ins($urandom_range(0, 4), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 4),
                  $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        cur.v = $urandom_range(0, 4) != 0;
        have = 1;
      end
      s = cur;
      s.fl = $urandom_range(0, 9) == 0;
      s.r  = $urandom_range(0, 199) == 0;
      step(s, iss);
      if (iss || s.fl || s.r || !s.v) have = 0;
    end
    idle(2);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
